// File: rtl/eu_wb_stage_way0_pkg.sv
// Shared definitions for the way0 writeback stage: default widths,
// the buffered entry layout and the effective-write helper.
package eu_wb_stage_way0_pkg;

    localparam int WB_DEPTH = 2;
    localparam int WB_XLEN  = 64;
    localparam int WB_AW    = 32;
    localparam int RA_W     = 5;

    // One buffered execute result, oldest-first in the FIFO.
    typedef struct packed {
        logic [RA_W-1:0]    rd_addr;
        logic               wen;
        logic [WB_XLEN-1:0] data;
        logic [WB_AW-1:0]   pc;
    } wb_entry_t;

    // Writes to x0 are discarded at capture time so nothing downstream
    // (regfile strobe, forwarding) has to special-case register zero.
    function automatic logic eff_wen(input logic wen, input logic [RA_W-1:0] rd);
        return wen && (rd != '0);
    endfunction

endpackage

// File: rtl/eu_wb_stage_way0_if.sv
// Result bus from the way0 execute unit into the writeback stage.
interface eu_wb_stage_way0_if
    import eu_wb_stage_way0_pkg::*;
#(
    parameter int XLEN = WB_XLEN,
    parameter int AW   = WB_AW
);
    logic            valid_i;
    logic            ready_o;
    logic [RA_W-1:0] rdAddr_i;
    logic            rdWriteEnable_i;
    logic [XLEN-1:0] rdWriteData_i;
    logic [AW-1:0]   instAddr_i;

    // Execute unit side: produces results, observes backpressure.
    modport master (
        output valid_i, rdAddr_i, rdWriteEnable_i, rdWriteData_i, instAddr_i,
        input  ready_o
    );

    // Writeback stage side: consumes results, drives backpressure.
    modport slave (
        input  valid_i, rdAddr_i, rdWriteEnable_i, rdWriteData_i, instAddr_i,
        output ready_o
    );
endinterface

// File: rtl/eu_wb_stage_way0_fwd.sv
// Youngest-match forwarding search across the pending writeback entries.
// Age order is walked from wr_ptr-1 back towards rd_ptr, limited to the
// number of occupied entries, so stale slots are never considered.
module wb_fwd_lookup_way0
    import eu_wb_stage_way0_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  wb_entry_t          ent [DEPTH],
    input  logic [PW-1:0]      wr_ptr,
    input  logic [CW-1:0]      count,
    input  logic [RA_W-1:0]    rs_addr,
    output logic               hit,
    output logic [WB_XLEN-1:0] data
);

    logic [PW-1:0] idx;

    // Scan youngest first; the first qualifying entry found is kept.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = wr_ptr - PW'(k + 1);
            if (!hit && (CW'(k) < count) && (rs_addr != '0) &&
                ent[idx].wen && (ent[idx].rd_addr == rs_addr)) begin
                hit  = 1'b1;
                data = ent[idx].data;
            end
        end
    end

endmodule

// File: rtl/eu_wb_stage_way0.sv
// Way0 writeback stage: in-order FIFO between the execute unit and the
// register-file write port, with rs1/rs2 forwarding over pending entries
// and a free-running retired-instruction counter.
module eu_wb_stage_way0
    import eu_wb_stage_way0_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int XLEN  = WB_XLEN,
    parameter int AW    = WB_AW
) (
    input  logic                 clk,
    input  logic                 reset_n,
    eu_wb_stage_way0_if.slave    eu,
    input  logic                 writeReady_i,
    output logic                 rdWriteEnable_o,
    output logic [RA_W-1:0]      rdAddr_o,
    output logic [XLEN-1:0]      rdWriteData_o,
    input  logic [RA_W-1:0]      rs1Addr_i,
    input  logic [RA_W-1:0]      rs2Addr_i,
    output logic                 rs1FwdHit_o,
    output logic [XLEN-1:0]      rs1FwdData_o,
    output logic                 rs2FwdHit_o,
    output logic [XLEN-1:0]      rs2FwdData_o,
    output logic                 retireValid_o,
    output logic [AW-1:0]        retirePc_o,
    output logic [63:0]          retireCount_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg,  count_next;
    logic [63:0]   retire_count_reg, retire_count_next;

    wb_entry_t        ent_mem [DEPTH];
    wb_entry_t        head;
    wb_entry_t        new_ent;
    logic [DEPTH-1:0] ent_we;

    logic empty;
    logic full;
    logic push;
    logic pop;

    // Occupancy is decoded from registered state only, so backpressure to
    // the execute unit never depends on this cycle's regfile availability.
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign head  = ent_mem[rd_ptr_reg];

    assign eu.ready_o = !full;
    assign push       = eu.valid_i && !full;
    // Entries with no register write retire without waiting for the port.
    assign pop        = !empty && (writeReady_i || !head.wen);

    assign new_ent.rd_addr = eu.rdAddr_i;
    assign new_ent.wen     = eff_wen(eu.rdWriteEnable_i, eu.rdAddr_i);
    assign new_ent.data    = eu.rdWriteData_i;
    assign new_ent.pc      = eu.instAddr_i;

    // Per-slot write strobes: only the slot under the write pointer loads.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent_we
            assign ent_we[gi] = push && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    // Entry storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_we[i]) begin
                ent_mem[i] <= new_ent;
            end
        end
    end

    // Pointer, occupancy and retire-counter next-state.
    always_comb begin
        wr_ptr_next       = wr_ptr_reg;
        rd_ptr_next       = rd_ptr_reg;
        count_next        = count_reg;
        retire_count_next = retire_count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end
        if (pop) begin
            rd_ptr_next       = rd_ptr_reg + PW'(1);
            retire_count_next = retire_count_reg + 64'd1;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Control state; reset discards every pending entry without a write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            retire_count_reg <= '0;
        end else begin
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            count_reg        <= count_next;
            retire_count_reg <= retire_count_next;
        end
    end

    // Regfile port and retire trace are driven straight from the head slot.
    always_comb begin
        rdWriteEnable_o = !empty && head.wen;
        rdAddr_o        = empty ? '0 : head.rd_addr;
        rdWriteData_o   = empty ? '0 : XLEN'(head.data);
        retireValid_o   = pop;
        retirePc_o      = pop ? AW'(head.pc) : '0;
    end

    assign retireCount_o = retire_count_reg;

    logic [WB_XLEN-1:0] rs1_data;
    logic [WB_XLEN-1:0] rs2_data;

    wb_fwd_lookup_way0 #(.DEPTH(DEPTH)) u_fwd_rs1 (
        .ent     (ent_mem),
        .wr_ptr  (wr_ptr_reg),
        .count   (count_reg),
        .rs_addr (rs1Addr_i),
        .hit     (rs1FwdHit_o),
        .data    (rs1_data)
    );

    wb_fwd_lookup_way0 #(.DEPTH(DEPTH)) u_fwd_rs2 (
        .ent     (ent_mem),
        .wr_ptr  (wr_ptr_reg),
        .count   (count_reg),
        .rs_addr (rs2Addr_i),
        .hit     (rs2FwdHit_o),
        .data    (rs2_data)
    );

    assign rs1FwdData_o = XLEN'(rs1_data);
    assign rs2FwdData_o = XLEN'(rs2_data);

endmodule

// File: tb/tb_eu_wb_stage_way0.sv
// Bench for the way0 writeback stage: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against
// a queue-based model of the stage.
module tb_eu_wb_stage_way0;
    import eu_wb_stage_way0_pkg::*;

    localparam int DEPTH = 2;
    localparam int XLEN  = 64;
    localparam int AW    = 32;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic            writeReady_i;
    logic            rdWriteEnable_o;
    logic [4:0]      rdAddr_o;
    logic [XLEN-1:0] rdWriteData_o;
    logic [4:0]      rs1Addr_i, rs2Addr_i;
    logic            rs1FwdHit_o, rs2FwdHit_o;
    logic [XLEN-1:0] rs1FwdData_o, rs2FwdData_o;
    logic            retireValid_o;
    logic [AW-1:0]   retirePc_o;
    logic [63:0]     retireCount_o;

    always #5 clk = ~clk;

    eu_wb_stage_way0_if #(.XLEN(XLEN), .AW(AW)) eu();

    eu_wb_stage_way0 #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .eu              (eu),
        .writeReady_i    (writeReady_i),
        .rdWriteEnable_o (rdWriteEnable_o),
        .rdAddr_o        (rdAddr_o),
        .rdWriteData_o   (rdWriteData_o),
        .rs1Addr_i       (rs1Addr_i),
        .rs2Addr_i       (rs2Addr_i),
        .rs1FwdHit_o     (rs1FwdHit_o),
        .rs1FwdData_o    (rs1FwdData_o),
        .rs2FwdHit_o     (rs2FwdHit_o),
        .rs2FwdData_o    (rs2FwdData_o),
        .retireValid_o   (retireValid_o),
        .retirePc_o      (retirePc_o),
        .retireCount_o   (retireCount_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    wb_entry_t   q[$];
    logic [63:0] m_retired = '0;

    always @(negedge reset_n) begin
        q.delete();
        m_retired = '0;
    end

    // Apply the edge: retire the head if allowed, accept a result if room.
    always @(posedge clk) begin
        if (reset_n) begin
            bit        do_pop, do_push;
            wb_entry_t e;
            do_pop  = (q.size() > 0) && (writeReady_i || !q[0].wen);
            do_push = eu.valid_i && (q.size() < DEPTH);
            if (do_pop) begin
                $display("retire #%0d pc=%h rd=%0d wen=%0d data=%h",
                         m_retired + 1, q[0].pc, q[0].rd_addr, q[0].wen, q[0].data);
                void'(q.pop_front());
                m_retired++;
            end
            if (do_push) begin
                e.rd_addr = eu.rdAddr_i;
                e.wen     = eu.rdWriteEnable_i && (eu.rdAddr_i != 5'd0);
                e.data    = eu.rdWriteData_i;
                e.pc      = eu.instAddr_i;
                q.push_back(e);
            end
        end
    end

    // Expected outputs from the model queue and current inputs.
    logic        e_ready, e_wen, e_pop, e_h1, e_h2;
    logic [4:0]  e_rd;
    logic [63:0] e_data, e_d1, e_d2;
    logic [31:0] e_pc;

    always @(negedge clk) begin
        if (chk_en) begin
            e_ready = q.size() < DEPTH;
            e_wen   = (q.size() > 0) && q[0].wen;
            e_rd    = (q.size() > 0) ? q[0].rd_addr : 5'd0;
            e_data  = (q.size() > 0) ? q[0].data : 64'd0;
            e_pop   = (q.size() > 0) && (writeReady_i || !q[0].wen);
            e_pc    = e_pop ? q[0].pc : 32'd0;
            e_h1 = 1'b0; e_d1 = '0; e_h2 = 1'b0; e_d2 = '0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!e_h1 && rs1Addr_i != 0 && q[i].wen && q[i].rd_addr == rs1Addr_i) begin
                    e_h1 = 1'b1; e_d1 = q[i].data;
                end
                if (!e_h2 && rs2Addr_i != 0 && q[i].wen && q[i].rd_addr == rs2Addr_i) begin
                    e_h2 = 1'b1; e_d2 = q[i].data;
                end
            end
            check("ready_o",        64'(eu.ready_o),       64'(e_ready));
            check("rdWriteEnable",  64'(rdWriteEnable_o),  64'(e_wen));
            check("rdAddr",         64'(rdAddr_o),         64'(e_rd));
            check("rdWriteData",    rdWriteData_o,         e_data);
            check("rs1FwdHit",      64'(rs1FwdHit_o),      64'(e_h1));
            check("rs1FwdData",     rs1FwdData_o,          e_d1);
            check("rs2FwdHit",      64'(rs2FwdHit_o),      64'(e_h2));
            check("rs2FwdData",     rs2FwdData_o,          e_d2);
            check("retireValid",    64'(retireValid_o),    64'(e_pop));
            check("retirePc",       64'(retirePc_o),       64'(e_pc));
            check("retireCount",    retireCount_o,         m_retired);
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] pc_ctr = 32'h1000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic wen, input logic [63:0] d);
        eu.valid_i         = v;
        eu.rdAddr_i        = rd;
        eu.rdWriteEnable_i = wen;
        eu.rdWriteData_i   = d;
        eu.instAddr_i      = pc_ctr;
        pc_ctr             = pc_ctr + 32'd4;
    endtask

    initial begin
        bit acc;
        writeReady_i = 1'b1;
        rs1Addr_i = '0;
        rs2Addr_i = '0;
        drive(1'b0, 5'd0, 1'b0, 64'd0);
        #1 reset_n = 1'b0;
        #2;
        check("reset_wen", 64'(rdWriteEnable_o), 64'd0);
        check("reset_cnt", retireCount_o, 64'd0);
        step(); step();
        reset_n = 1'b1;
        chk_en  = 1'b1;
        #1;
        check("reset_ready", 64'(eu.ready_o), 64'd1);

        // single write, minimum latency
        drive(1'b1, 5'd5, 1'b1, 64'h1234);
        step();
        drive(1'b0, 5'd0, 1'b0, 64'd0);
        @(negedge clk);
        check("single_wen",  64'(rdWriteEnable_o), 64'd1);
        check("single_rd",   64'(rdAddr_o),        64'd5);
        check("single_data", rdWriteData_o,        64'h1234);
        step();
        check("single_cnt",  retireCount_o,        64'd1);

        // backpressure: A, B fill the FIFO, C held by the EU
        writeReady_i = 1'b0;
        drive(1'b1, 5'd1, 1'b1, 64'hA1);
        step();
        drive(1'b1, 5'd2, 1'b1, 64'hB2);
        step();
        drive(1'b1, 5'd4, 1'b1, 64'hC4);
        @(negedge clk);
        check("full_ready", 64'(eu.ready_o), 64'd0);
        step(); step();
        writeReady_i = 1'b1;
        @(negedge clk);
        check("order_A", 64'(rdAddr_o), 64'd1);
        step();
        @(negedge clk);
        check("order_B", 64'(rdAddr_o), 64'd2);
        step();
        drive(1'b0, 5'd0, 1'b0, 64'd0);
        @(negedge clk);
        check("order_C", 64'(rdAddr_o), 64'd4);
        step();
        check("bp_cnt", retireCount_o, 64'd4);

        // x0 write and no-write entries retire without the port
        writeReady_i = 1'b0;
        drive(1'b1, 5'd0, 1'b1, 64'h55);
        step();
        drive(1'b1, 5'd7, 1'b0, 64'h77);
        check("x0_wen", 64'(rdWriteEnable_o), 64'd0);
        step();
        drive(1'b0, 5'd0, 1'b0, 64'd0);
        @(negedge clk);
        check("nowr_wen", 64'(rdWriteEnable_o), 64'd0);
        step();
        check("nowr_cnt", retireCount_o, 64'd6);

        // forwarding priority: youngest of two rd=3 entries
        drive(1'b1, 5'd3, 1'b1, 64'hA);
        step();
        drive(1'b1, 5'd3, 1'b1, 64'hB);
        step();
        drive(1'b0, 5'd0, 1'b0, 64'd0);
        rs1Addr_i = 5'd3;
        rs2Addr_i = 5'd0;
        @(negedge clk);
        check("fwd_rs1_hit",  64'(rs1FwdHit_o),  64'd1);
        check("fwd_rs1_data", rs1FwdData_o,      64'hB);
        check("fwd_rs2_hit",  64'(rs2FwdHit_o),  64'd0);
        check("fwd_rs2_data", rs2FwdData_o,      64'd0);
        writeReady_i = 1'b1;
        step(); step();
        rs1Addr_i = '0;
        check("fwd_cnt", retireCount_o, 64'd8);

        // back-to-back push/pop at count=1 across pointer wraps
        drive(1'b1, 5'd9, 1'b1, 64'h500);
        for (int k = 0; k < 10; k++) begin
            step();
            if (k < 9) drive(1'b1, 5'd9, 1'b1, 64'h500 + 64'(k + 1));
            else       drive(1'b0, 5'd0, 1'b0, 64'd0);
            @(negedge clk);
            check("b2b_ready", 64'(eu.ready_o), 64'd1);
            check("b2b_data",  rdWriteData_o,  64'h500 + 64'(k));
        end
        step();
        check("b2b_cnt", retireCount_o, 64'd18);

        // asynchronous reset with two pending entries
        writeReady_i = 1'b0;
        drive(1'b1, 5'd9, 1'b1, 64'h99);
        step();
        drive(1'b1, 5'd10, 1'b1, 64'hAA);
        step();
        drive(1'b0, 5'd0, 1'b0, 64'd0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_wen",  64'(rdWriteEnable_o), 64'd0);
        check("arst_rd",   64'(rdAddr_o),        64'd0);
        check("arst_data", rdWriteData_o,        64'd0);
        check("arst_cnt",  retireCount_o,        64'd0);
        step(); step();
        reset_n = 1'b1;
        #1;
        check("post_ready", 64'(eu.ready_o),      64'd1);
        check("post_wen",   64'(rdWriteEnable_o), 64'd0);
        check("post_cnt",   retireCount_o,        64'd0);

        // randomized traffic; the EU holds a result until accepted
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = eu.valid_i && eu.ready_o;
            step();
            writeReady_i = ($urandom_range(0, 9) < 7);
            rs1Addr_i    = 5'($urandom_range(0, 7));
            rs2Addr_i    = 5'($urandom_range(0, 7));
            if (!eu.valid_i || acc)
                drive($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), {$urandom, $urandom});
        end
        drive(1'b0, 5'd0, 1'b0, 64'd0);
        writeReady_i = 1'b1;
        step(); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
